// File: rtl/ones_count_seq.sv
// Multi-cycle handshaked population counter: counts CHUNK bits of a latched WIDTH-bit word per clock.
// Optional running total of delivered counts is built when ONES_COUNT_ACC_EN is defined.
module ones_count_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2,
  parameter int TW    = 16,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dat_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CW-1:0]    count,
  output logic             is_zero,
  output logic             is_full,
  output logic             out_valid,
`ifdef ONES_COUNT_ACC_EN
  input  logic             out_ready,
  input  logic             acc_clr,
  output logic [TW-1:0]    total
`else
  input  logic             out_ready
`endif
);

  localparam int BEATS = WIDTH / CHUNK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0 || TW < 1) begin : g_bad_params
    $error("ones_count_seq: illegal WIDTH/CHUNK/TW combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    partial;
  logic [BW-1:0]    beat;
  logic [CW-1:0]    chunk_ones;
  logic [CW-1:0]    sum_nxt;
  logic             last_beat;
  logic             accept;

  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_ones = chunk_ones + CW'(sh[i]);
    end
  end

  assign sum_nxt   = partial + chunk_ones;
  assign last_beat = (beat == BW'(BEATS - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Result registers only move on the final beat, so they hold steady through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      partial <= '0;
      beat    <= '0;
      count   <= '0;
      is_zero <= 1'b0;
      is_full <= 1'b0;
    end else if (accept) begin
      sh      <= dat_in;
      partial <= '0;
      beat    <= '0;
    end else if (state == COUNT) begin
      sh      <= sh >> CHUNK;
      partial <= sum_nxt;
      beat    <= beat + BW'(1);
      if (last_beat) begin
        count   <= sum_nxt;
        is_zero <= (sum_nxt == '0);
        is_full <= (sum_nxt == CW'(WIDTH));
      end
    end
  end

`ifdef ONES_COUNT_ACC_EN
  // A clear in the handshake cycle drops that word's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total <= '0;
    end else if (acc_clr) begin
      total <= '0;
    end else if (out_valid && out_ready) begin
      total <= total + TW'(count);
    end
  end
`endif

endmodule

// File: tb/tb_ones_count_seq.sv
// Self-checking bench for ones_count_seq: per-cycle reference model plus directed literal checks.
// Build with ONES_COUNT_ACC_EN defined to also exercise the running total (TW=4).
module tb_ones_count_seq;

  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam int BEATS = WIDTH / CHUNK;
`ifdef ONES_COUNT_ACC_EN
  localparam int TW = 4;
`else
  localparam int TW = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dat_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] count;
  logic       is_zero;
  logic       is_full;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       acc_clr = 1'b0;
  logic [TW-1:0] total;

  logic [31:0] d32 = '0;
  logic        v32 = 1'b0;
  logic        r32 = 1'b1;
  logic        acc_clr32 = 1'b0;
  logic        ir_a, ir_b, z_a, z_b, f_a, f_b, ov_a, ov_b;
  logic [5:0]  c_a, c_b;
  logic [15:0] tot_a, tot_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ones_count_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .in_valid(in_valid), .in_ready(in_ready),
    .count(count), .is_zero(is_zero), .is_full(is_full), .out_valid(out_valid),
`ifdef ONES_COUNT_ACC_EN
    .acc_clr(acc_clr), .total(total),
`endif
    .out_ready(out_ready)
  );

  ones_count_seq #(.WIDTH(32), .CHUNK(32)) u_wide (
    .clk(clk), .rst_n(rst_n), .dat_in(d32), .in_valid(v32), .in_ready(ir_a),
    .count(c_a), .is_zero(z_a), .is_full(f_a), .out_valid(ov_a),
`ifdef ONES_COUNT_ACC_EN
    .acc_clr(acc_clr32), .total(tot_a),
`endif
    .out_ready(r32)
  );

  ones_count_seq #(.WIDTH(32), .CHUNK(1)) u_serial (
    .clk(clk), .rst_n(rst_n), .dat_in(d32), .in_valid(v32), .in_ready(ir_b),
    .count(c_b), .is_zero(z_b), .is_full(f_b), .out_valid(ov_b),
`ifdef ONES_COUNT_ACC_EN
    .acc_clr(acc_clr32), .total(tot_b),
`endif
    .out_ready(r32)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word is outstanding from acceptance until its output handshake;
  // its result must appear exactly BEATS edges after the accepting edge.
  bit            outstanding = 1'b0;
  int            acc_edge = 0;
  int            exp_cnt = 0;
  logic [TW-1:0] tot = '0;

  always @(negedge clk) begin
    bit ev;
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_is_zero", is_zero, 0);
      check("rst_is_full", is_full, 0);
      outstanding = 1'b0;
      tot = '0;
    end else begin
      ev = outstanding && (cyc >= acc_edge + BEATS);
      check("in_ready", in_ready, !outstanding);
      check("out_valid", out_valid, ev);
      if (ev) begin
        check("count", count, exp_cnt);
        check("is_zero", is_zero, exp_cnt == 0);
        check("is_full", is_full, exp_cnt == WIDTH);
      end
`ifdef ONES_COUNT_ACC_EN
      check("total", total, tot);
      if (acc_clr) tot = '0;
      else if (ev && out_ready) tot = tot + TW'(exp_cnt);
`endif
      if (ev && out_ready) begin
        outstanding = 1'b0;
      end else if (!outstanding && in_valid) begin
        outstanding = 1'b1;
        acc_edge = cyc + 1;
        exp_cnt = $countones(dat_in);
      end
    end
  end

  task automatic send(input logic [7:0] w);
    bit ok = 1'b0;
    dat_in = w;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_a;
    int lat_b;
    logic [5:0] cnt_a;
    logic [5:0] cnt_b;
    logic fa;
    logic fb;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("init_out_valid", out_valid, 0);
    check("init_in_ready", in_ready, 1);

    // Flag corners with hand-computed results
    send(8'h00);
    wait_done();
    check("lit_zero_count", count, 0);
    check("lit_zero_flag", is_zero, 1);
    @(posedge clk); #1;
    send(8'hFF);
    wait_done();
    check("lit_ff_count", count, 8);
    check("lit_ff_full", is_full, 1);
    @(posedge clk); #1;

    for (int w = 0; w < 256; w++) send(8'(w));
    wait_done();
    @(posedge clk); #1;

    // Backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    send(8'hA5);
    wait_done();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_count", count, 4);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Reset while counting discards the word
    send(8'hFF);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_count", count, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);
    end

`ifdef ONES_COUNT_ACC_EN
    @(posedge clk); #1 acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    send(8'hFF);
    wait_done();
    @(posedge clk); @(negedge clk);
    check("acc_first", total, 8);
    #1;
    send(8'hFF);
    wait_done();
    @(posedge clk); @(negedge clk);
    check("acc_wrap", total, 0);
    #1;
    send(8'h03);
    wait_done();
    @(posedge clk); @(negedge clk);
    check("acc_add", total, 2);
    #1;
    out_ready = 1'b0;
    send(8'h0F);
    wait_done();
    @(posedge clk); #1 begin acc_clr = 1'b1; out_ready = 1'b1; end
    @(posedge clk); #1 acc_clr = 1'b0;
    @(negedge clk);
    check("acc_clr_wins", total, 0);
    #1;
`endif

    // Random traffic, including input toggling during COUNT and random stalls
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      dat_in = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef ONES_COUNT_ACC_EN
      acc_clr = ($urandom_range(0, 15) == 0);
`endif
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    acc_clr = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Parameter corners: one-beat and bit-serial 32-bit counters
    d32 = 32'hFFFF_FFFF;
    v32 = 1'b1;
    @(posedge clk); #1 v32 = 1'b0;
    lat_a = 0; lat_b = 0; cnt_a = '0; cnt_b = '0; fa = 1'b0; fb = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov_a && lat_a == 0) begin lat_a = n; cnt_a = c_a; fa = f_a; end
      if (ov_b && lat_b == 0) begin lat_b = n; cnt_b = c_b; fb = f_b; end
    end
    check("w32c32_latency", lat_a, 1);
    check("w32c32_count", cnt_a, 32);
    check("w32c32_full", fa, 1);
    check("w32c1_latency", lat_b, 32);
    check("w32c1_count", cnt_b, 32);
    check("w32c1_full", fb, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
